// File: rtl/tft_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tft_pixel_fifo
// Purpose  : Captures in-window pixels from the video generator, packs them
//            into the panel's 16-bit word, and buffers them in a small FIFO
//            with a start-of-frame flag. The TFT write engine drains the
//            FIFO through a valid/ready handshake. When a pixel has to be
//            dropped (FIFO full), the rest of that frame is discarded until
//            the next pixel (0,0), so the panel write pointer stays in step
//            with the per-frame memory-write command.
// Ports    : clk, rst_n (sync, active-low)
//            r, g, b [2:0]   pixel colour
//            hc, vc  [8:0]   video counters
//            pix_en          pixel strobe
//            out_data[15:0], out_sof, out_valid, out_ready  writer handshake
//            overflow        one-cycle pulse per dropped pixel
//            level           FIFO occupancy, 0..2^DEPTH_LOG2
// Options  : TFT_PIXFIFO_REPLICATE_EN - fill padding bits with replicated
//            colour MSBs instead of zeros (white -> 16'hFFFF).
// Revision : 1.0 - initial release
// ============================================================================
module tft_pixel_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            r,
    input  logic [2:0]            g,
    input  logic [2:0]            b,
    input  logic [8:0]            hc,
    input  logic [8:0]            vc,
    input  logic                  pix_en,
    output logic [15:0]           out_data,
    output logic                  out_sof,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                 c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_LEVEL = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [8:0]         c_H_LIMIT    = 9'(H_ACTIVE);
    localparam logic [8:0]         c_V_LIMIT    = 9'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_RUN      = 2'd1,
        ST_RESYNC   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [16:0]             r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_level;
    logic                    r_overflow;

    logic                    w_in_window;
    logic                    w_is_sof;
    logic                    w_full;
    logic                    w_out_valid;
    logic                    w_pop;
    logic                    w_can_push;
    logic                    w_push;
    logic                    w_drop;
    logic [15:0]             w_pixel;

    // ------------------------------------------------------------------
    // Pixel qualification and packing
    // ------------------------------------------------------------------
    assign w_in_window = pix_en && (hc < c_H_LIMIT) && (vc < c_V_LIMIT);
    assign w_is_sof    = w_in_window && (hc == 9'd0) && (vc == 9'd0);

`ifdef TFT_PIXFIFO_REPLICATE_EN
    assign w_pixel = {b, b[2:1], g, g, r, r[2:1]};
`else
    assign w_pixel = {b, 2'b00, g, 3'b000, r, 2'b00};
`endif

    // ------------------------------------------------------------------
    // FIFO status; a full FIFO still accepts a push when it pops the
    // same cycle, which keeps one-in/one-out throughput at full level.
    // ------------------------------------------------------------------
    assign w_full      = (r_level == c_FULL_LEVEL);
    assign w_out_valid = (r_level != '0);
    assign w_pop       = w_out_valid && out_ready;
    assign w_can_push  = !w_full || w_pop;

    // ------------------------------------------------------------------
    // Capture state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_SOF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_in_window) begin
                    if (w_can_push) begin
                        w_push = 1'b1;
                    end else begin
                        w_drop       = 1'b1;
                        w_state_next = ST_RESYNC;
                    end
                end
            end
            default: begin
                // WAIT_SOF and RESYNC: only a frame start re-arms capture.
                // A SOF that cannot be stored (only reachable in RESYNC
                // with a still-full FIFO) is dropped and we keep waiting.
                if (w_is_sof) begin
                    if (w_can_push) begin
                        w_push       = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_drop       = 1'b1;
                        w_state_next = ST_RESYNC;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and overflow pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once the write
    // pointer has passed it, and the pointers are reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= {w_is_sof, w_pixel};
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head entry, forced to zero when empty so that stale
    // storage never shows on the bus.
    // ------------------------------------------------------------------
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_mem[r_rd_ptr][15:0] : 16'h0000;
    assign out_sof   = w_out_valid ? r_mem[r_rd_ptr][16]   : 1'b0;
    assign overflow  = r_overflow;
    assign level     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_tft_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_pixel_fifo
// Purpose  : Self-checking bench for tft_pixel_fifo. Every accepted pixel's
//            expected word is queued when it is driven; a monitor pops and
//            compares whenever the DUT completes a handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_pixel_fifo;

    localparam int c_DEPTH_LOG2 = 4;
    localparam int c_DEPTH      = 1 << c_DEPTH_LOG2;

`ifdef TFT_PIXFIFO_REPLICATE_EN
    localparam logic [15:0] c_WHITE = 16'hFFFF;
`else
    localparam logic [15:0] c_WHITE = 16'hE71C;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [2:0]             r, g, b;
    logic [8:0]             hc, vc;
    logic                   pix_en;
    logic [15:0]            out_data;
    logic                   out_sof;
    logic                   out_valid;
    logic                   out_ready;
    logic                   overflow;
    logic [c_DEPTH_LOG2:0]  level;

    logic [16:0]            exp_q[$];
    int                     n_tests;
    int                     n_fail;
    int                     ovf_cnt;

    tft_pixel_fifo #(
        .DEPTH_LOG2 (c_DEPTH_LOG2),
        .H_ACTIVE   (320),
        .V_ACTIVE   (240)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r         (r),
        .g         (g),
        .b         (b),
        .hc        (hc),
        .vc        (vc),
        .pix_en    (pix_en),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack(input logic [2:0] pr, input logic [2:0] pg,
                                         input logic [2:0] pb);
`ifdef TFT_PIXFIFO_REPLICATE_EN
        return {pb, pb[2:1], pg, pg, pr, pr[2:1]};
`else
        return {pb, 2'b00, pg, 3'b000, pr, 2'b00};
`endif
    endfunction

    // Called at posedge+1; drives one pixel strobe and returns at the
    // following posedge+1. Back-to-back calls give consecutive strobes.
    task automatic pix(input int x, input int y, input logic [2:0] pr,
                       input logic [2:0] pg, input logic [2:0] pb, input bit accept);
        hc     = 9'(x);
        vc     = 9'(y);
        r      = pr;
        g      = pg;
        b      = pb;
        pix_en = 1'b1;
        if (accept) begin
            exp_q.push_back({(x == 0 && y == 0), pack(pr, pg, pb)});
        end
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc;
        out_ready = 1'b1;
        cyc = 0;
        while (level != 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_drain_done"}, 32'(level == 0), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes at the
    // next posedge unless reset is asserted.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("pop_data", 32'(out_data), 32'(e[15:0]));
                check("pop_sof", 32'(out_sof), 32'(e[16]));
            end
        end
        if (rst_n && overflow) begin
            ovf_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        ovf_cnt   = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        pix_en    = 1'b0;
        hc        = '0;
        vc        = '0;
        r         = '0;
        g         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sof", 32'(out_sof), 32'd0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        @(posedge clk);
        #1;

        // WAIT_SOF ignores a non-origin pixel, then accepts (0,0)
        pix(5, 3, 3'd7, 3'd7, 3'd7, 1'b0);
        check("waitsof_level", 32'(level), 32'd0);
        pix(0, 0, 3'd7, 3'd7, 3'd7, 1'b1);
        check("sof_valid", 32'(out_valid), 32'd1);
        check("sof_flag", 32'(out_sof), 32'd1);
        check("sof_white", 32'(out_data), 32'(c_WHITE));
        drain("first");

        // Window edge in RUN with ready high
        out_ready = 1'b1;
        pix(318, 239, 3'd1, 3'd2, 3'd3, 1'b1);
        pix(319, 239, 3'd4, 3'd5, 3'd6, 1'b1);
        pix(320, 239, 3'd7, 3'd0, 3'd7, 1'b0);
        drain("edge");
        check("edge_no_ovf", 32'(ovf_cnt), 32'd0);

        // Fill to full, then overflow
        out_ready = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) begin
            pix(i, 1, 3'(i), 3'(i + 1), 3'(i + 3), 1'b1);
        end
        check("fill_level", 32'(level), 32'(c_DEPTH));
        check("fill_no_ovf", 32'(ovf_cnt), 32'd0);
        pix(c_DEPTH, 1, 3'd2, 3'd2, 3'd2, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'(c_DEPTH));
        @(posedge clk);
        #1;
        check("ovf_one_cycle", 32'(overflow), 32'd0);
        drain("full");
        check("ovf_count", 32'(ovf_cnt), 32'd1);

        // RESYNC discards until (0,0) even with room available
        pix(20, 1, 3'd1, 3'd1, 3'd1, 1'b0);
        pix(5, 200, 3'd2, 3'd3, 3'd4, 1'b0);
        check("resync_level", 32'(level), 32'd0);
        check("resync_no_ovf", 32'(ovf_cnt), 32'd1);
        pix(0, 0, 3'd5, 3'd1, 3'd6, 1'b1);
        check("resync_sof_level", 32'(level), 32'd1);
        check("resync_sof_flag", 32'(out_sof), 32'd1);

        // Fill again, then push and pop on the same edge while full
        for (int i = 1; i < c_DEPTH; i++) begin
            pix(i, 0, 3'(i + 2), 3'(i), 3'(i + 5), 1'b1);
        end
        check("refill_level", 32'(level), 32'(c_DEPTH));
        out_ready = 1'b1;
        pix(c_DEPTH, 0, 3'd6, 3'd3, 3'd1, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        check("pushpop_level", 32'(level), 32'(c_DEPTH));
        check("pushpop_no_ovf", 32'(overflow), 32'd0);

        // Head holds while stalled
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", 32'(out_data), 32'(exp_q[0][15:0]));
            check("hold_sof", 32'(out_sof), 32'(exp_q[0][16]));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("single_pop_level", 32'(level), 32'(c_DEPTH - 1));
        @(posedge clk);
        #1;
        drain("pushpop");
        check("pushpop_ovf_count", 32'(ovf_cnt), 32'd1);

        // Mid-frame reset with seven entries
        for (int i = 0; i < 7; i++) begin
            pix(i, 5, 3'(i), 3'(7 - i), 3'(i + 1), 1'b1);
        end
        check("pre_rst_level", 32'(level), 32'd7);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'h0);
        @(posedge clk);
        #1;
        pix(7, 5, 3'd3, 3'd3, 3'd3, 1'b0);
        pix(10, 10, 3'd4, 3'd4, 3'd4, 1'b0);
        check("postrst_ignored", 32'(level), 32'd0);
        pix(0, 0, 3'd7, 3'd7, 3'd7, 1'b1);
        check("postrst_sof", 32'(out_sof), 32'd1);
        check("postrst_data", 32'(out_data), 32'(c_WHITE));
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
